// File: rtl/dino_frame_renderer.sv
// rtl/dino_frame_renderer.sv - per-frame rectangle renderer for the dino game-state bus
// Optional previous-box erase instead of full band clear: DINO_RENDER_ERASE_EN
module dino_frame_renderer #(
  parameter int         SCREEN_W      = 640,
  parameter int         SCREEN_H      = 480,
  parameter int         CLEAR_TOP     = 0,
  parameter int         PLAYER_X      = 64,
  parameter logic [2:0] BG_COLOUR     = 3'b111,
  parameter logic [2:0] PLAYER_COLOUR = 3'b000,
  parameter logic [2:0] CACTUS_COLOUR = 3'b010,
  parameter logic [2:0] BIRD_COLOUR   = 3'b100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_frame_tick,
  input  logic [10:0] i_y_pos,
  input  logic [7:0]  i_cactus_h,
  input  logic [39:0] i_cactus_x,
  input  logic [39:0] i_bird_x,
  input  logic [39:0] i_bird_y,
  input  logic [1:0]  i_animation_cycle,
  input  logic        i_plot_ready,
  output logic [9:0]  o_vga_x,
  output logic [8:0]  o_vga_y,
  output logic [2:0]  o_vga_colour,
  output logic        o_plot,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CLEAR, S_SEL, S_DRAW, S_DONE} state_t;

  localparam logic signed [11:0] W_S   = 12'(SCREEN_W);
  localparam logic signed [11:0] H_S   = 12'(SCREEN_H);
  localparam logic signed [11:0] TOP_S = 12'(CLEAR_TOP);
  localparam logic signed [11:0] PX_S  = 12'(PLAYER_X);
  localparam logic signed [11:0] BOX_W = 12'sd32;
  localparam logic [9:0]         X_OFF = 10'd1023;

  state_t r_state;

  logic [10:0] r_y_pos;
  logic [7:0]  r_cactus_h;
  logic [39:0] r_cactus_x;
  logic [39:0] r_bird_x;
  logic [39:0] r_bird_y;
  logic        r_anim0;

  logic [3:0]         r_obj;
  logic signed [11:0] r_px;
  logic signed [11:0] r_py;
  logic signed [11:0] r_x0;
  logic signed [11:0] r_x1;
  logic signed [11:0] r_y1;
  logic [2:0]         r_colour;
  logic               r_is_player;

  logic [10:0] w_src_y_pos;
  logic [7:0]  w_src_cactus_h;
  logic [39:0] w_src_cactus_x;
  logic [39:0] w_src_bird_x;
  logic [39:0] w_src_bird_y;
  logic        w_src_player_vld;
  logic        w_erase;
  logic        w_unused;

`ifdef DINO_RENDER_ERASE_EN
  logic        r_erase;
  logic [10:0] r_prev_y_pos;
  logic [7:0]  r_prev_cactus_h;
  logic [39:0] r_prev_cactus_x;
  logic [39:0] r_prev_bird_x;
  logic [39:0] r_prev_bird_y;
  logic        r_prev_player_vld;

  // The erase pass walks last frame's boxes through the same selector as the draw pass
  assign w_erase          = r_erase;
  assign w_src_y_pos      = r_erase ? r_prev_y_pos    : r_y_pos;
  assign w_src_cactus_h   = r_erase ? r_prev_cactus_h : r_cactus_h;
  assign w_src_cactus_x   = r_erase ? r_prev_cactus_x : r_cactus_x;
  assign w_src_bird_x     = r_erase ? r_prev_bird_x   : r_bird_x;
  assign w_src_bird_y     = r_erase ? r_prev_bird_y   : r_bird_y;
  assign w_src_player_vld = r_erase ? r_prev_player_vld : 1'b1;
`else
  assign w_erase          = 1'b0;
  assign w_src_y_pos      = r_y_pos;
  assign w_src_cactus_h   = r_cactus_h;
  assign w_src_cactus_x   = r_cactus_x;
  assign w_src_bird_x     = r_bird_x;
  assign w_src_bird_y     = r_bird_y;
  assign w_src_player_vld = 1'b1;
`endif

  assign w_unused = i_animation_cycle[1];

  logic [9:0]         w_cx [4];
  logic [9:0]         w_bx [4];
  logic [9:0]         w_by [4];
  logic [1:0]         w_ch [4];
  logic [1:0]         w_sub;
  logic [2:0]         w_hp1;
  logic signed [11:0] w_x1;
  logic signed [11:0] w_y1;
  logic signed [11:0] w_h;
  logic signed [11:0] w_y0;
  logic               w_active;
  logic [2:0]         w_colour;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_cx[i] = w_src_cactus_x[i*10 +: 10];
      w_bx[i] = w_src_bird_x[i*10 +: 10];
      w_by[i] = w_src_bird_y[i*10 +: 10];
      w_ch[i] = w_src_cactus_h[i*2 +: 2];
    end
  end

  // Cactus slots are objects 1..4 and bird slots 5..8, so obj-1 mod 4 picks the slot for both
  assign w_sub = 2'(r_obj - 4'd1);
  assign w_hp1 = {1'b0, w_ch[w_sub]} + 3'd1;

  always_comb begin
    w_x1     = PX_S + BOX_W;
    w_y1     = {1'b0, w_src_y_pos};
    w_h      = BOX_W;
    w_active = w_src_player_vld;
    w_colour = PLAYER_COLOUR;
    if (r_obj >= 4'd1 && r_obj <= 4'd4) begin
      w_x1     = {2'b00, w_cx[w_sub]};
      w_y1     = H_S;
      w_h      = {6'd0, w_hp1, 3'b000};
      w_active = (w_cx[w_sub] != X_OFF);
      w_colour = CACTUS_COLOUR;
    end else if (r_obj >= 4'd5) begin
      w_x1     = {2'b00, w_bx[w_sub]};
      w_y1     = {2'b00, w_by[w_sub]};
      w_active = (w_bx[w_sub] != X_OFF);
      w_colour = BIRD_COLOUR;
    end
  end

  assign w_y0 = w_y1 - w_h;

  logic w_on_screen;
  logic w_right_half;
  logic w_anim_ok;
  logic w_vis;
  logic w_stall;

  assign w_on_screen  = (r_px >= 12'sd0) && (r_px < W_S) && (r_py >= 12'sd0) && (r_py < H_S);
  assign w_right_half = (r_px >= (r_x0 + 12'sd16));
  // Legs: the player's bottom four rows show only the half of the box chosen by the animation phase
  assign w_anim_ok    = !(r_state == S_DRAW && r_is_player && r_py >= (r_y1 - 12'sd4))
                        || (w_right_half == r_anim0);
  assign w_vis        = w_on_screen && w_anim_ok;
  assign w_stall      = o_plot && !i_plot_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      o_plot       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      o_vga_x      <= '0;
      o_vga_y      <= '0;
      o_vga_colour <= BG_COLOUR;
`ifdef DINO_RENDER_ERASE_EN
      r_erase           <= 1'b0;
      r_prev_player_vld <= 1'b0;
      r_prev_cactus_x   <= {4{X_OFF}};
      r_prev_bird_x     <= {4{X_OFF}};
`endif
    end else begin
      o_frame_done <= 1'b0;
      if (i_frame_tick && r_state != S_IDLE)
        o_overrun <= 1'b1;
      // A pending pixel freezes the whole walker, so frame_done only follows the last accepted pixel
      if (!w_stall) begin
        o_plot <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (i_frame_tick)
              r_state <= S_SNAP;
          end
          S_SNAP: begin
            r_y_pos    <= i_y_pos;
            r_cactus_h <= i_cactus_h;
            r_cactus_x <= i_cactus_x;
            r_bird_x   <= i_bird_x;
            r_bird_y   <= i_bird_y;
            r_anim0    <= i_animation_cycle[0];
            o_busy     <= 1'b1;
            r_obj      <= 4'd0;
`ifdef DINO_RENDER_ERASE_EN
            r_erase    <= 1'b1;
            r_state    <= S_SEL;
`else
            r_x0        <= 12'sd0;
            r_x1        <= W_S;
            r_y1        <= H_S;
            r_px        <= 12'sd0;
            r_py        <= TOP_S;
            r_colour    <= BG_COLOUR;
            r_is_player <= 1'b0;
            r_state     <= S_CLEAR;
`endif
          end
          S_CLEAR, S_DRAW: begin
            o_plot       <= w_vis;
            o_vga_x      <= r_px[9:0];
            o_vga_y      <= r_py[8:0];
            o_vga_colour <= r_colour;
            if (r_px == r_x1 - 12'sd1) begin
              r_px <= r_x0;
              if (r_py == r_y1 - 12'sd1)
                r_state <= S_SEL;
              else
                r_py <= r_py + 12'sd1;
            end else begin
              r_px <= r_px + 12'sd1;
            end
          end
          S_SEL: begin
            if (r_obj == 4'd9) begin
`ifdef DINO_RENDER_ERASE_EN
              if (r_erase) begin
                r_erase <= 1'b0;
                r_obj   <= 4'd0;
              end else begin
                r_state <= S_DONE;
              end
`else
              r_state <= S_DONE;
`endif
            end else begin
              r_obj <= r_obj + 4'd1;
              if (w_active) begin
                r_x0        <= w_x1 - BOX_W;
                r_x1        <= w_x1;
                r_y1        <= w_y1;
                r_px        <= w_x1 - BOX_W;
                r_py        <= w_y0;
                r_colour    <= w_erase ? BG_COLOUR : w_colour;
                r_is_player <= (r_obj == 4'd0);
                r_state     <= w_erase ? S_CLEAR : S_DRAW;
              end
            end
          end
          S_DONE: begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            r_state      <= S_IDLE;
`ifdef DINO_RENDER_ERASE_EN
            r_prev_y_pos      <= r_y_pos;
            r_prev_cactus_h   <= r_cactus_h;
            r_prev_cactus_x   <= r_cactus_x;
            r_prev_bird_x     <= r_bird_x;
            r_prev_bird_y     <= r_bird_y;
            r_prev_player_vld <= 1'b1;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
